ex_muldiv_stage: RTL and testbench

Parametrised next-generation execute stage. Combines the single-cycle integer ALU with an iterative multiply/divide unit that owns the HI/LO registers. Sits between the ID/EX and EX/ME pipeline registers. Operands arrive already forwarded. The block raises StallE to freeze the front of the pipeline while a multi-cycle operation runs.

---
 rtl/ex_muldiv_stage.sv | 188 ++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle integer ALU plus an iterative multiply/divide
// unit that owns HI/LO. A multi-cycle op raises StallE from its issue cycle
// until the cycle in which HI/LO are written. The following cycle (DONE)
// releases the held instruction.
//
// Handshake: the stage has no valid/ready pair. StallE acts as "not ready".
// While StallE is high, upstream holds its inputs, and EX/ME inserts a bubble.
// When StallE is low, the instruction in EX is consumed in that cycle.
module ex_muldiv_stage #(
  parameter int XLEN = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      MdOpE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic [XLEN-1:0] ALUResultE,
  output logic            StallE,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            BusyE,
  output logic [1:0]      DbgStateE
);

  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic [XLEN-1:0]  a_raw_q;
  logic [XLEN-1:0]  b_mag_q;
  logic [XLEN-1:0]  acc_q;
  logic [XLEN-1:0]  lo_work_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;

  logic            start;
  logic            last;
  logic            sgn;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  // Issue decode and operand magnitudes for signed ops.
  always_comb begin
    start = MdOpE[2] & ~FlushE;
    last  = (cnt_q == CNT_W'(1));
    sgn   = ~MdOpE[0];
    a_mag = (sgn && SrcAE[XLEN-1]) ? (-SrcAE) : SrcAE;
    b_mag = (sgn && SrcBE[XLEN-1]) ? (-SrcBE) : SrcBE;
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: DONE ignores MdOpE so that the held op does not re-issue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  begin
        if (FlushE)    state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. A flush drops the stall in the same cycle, and reset forces it low.
  always_comb begin
    StallE    = ~Reset & (((state_q == S_IDLE) & start) |
                          ((state_q == S_BUSY) & ~FlushE));
    BusyE     = ~Reset & (state_q == S_BUSY);
    DbgStateE = state_q;
  end

  logic [XLEN:0]     m_sum;
  logic [XLEN-1:0]   m_acc, m_lo;
  logic [XLEN:0]     d_shift;
  logic              d_ge;
  logic [XLEN-1:0]   d_diff;
  logic [XLEN-1:0]   d_acc, d_lo;
  logic [XLEN-1:0]   acc_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   hi_res, lo_res;

  // One iteration step: the mult step is a shift-add on {acc, multiplier}.
  // The div step is a restoring subtract on {rem, dividend}. The final step
  // also applies the sign fix-up and the divide-by-zero override.
  always_comb begin
    m_sum   = {1'b0, acc_q} + (lo_work_q[0] ? {1'b0, b_mag_q} : '0);
    m_acc   = m_sum[XLEN:1];
    m_lo    = {m_sum[0], lo_work_q[XLEN-1:1]};
    d_shift = {acc_q, lo_work_q[XLEN-1]};
    d_ge    = (d_shift >= {1'b0, b_mag_q});
    d_diff  = d_shift[XLEN-1:0] - b_mag_q;
    d_acc   = d_ge ? d_diff : d_shift[XLEN-1:0];
    d_lo    = {lo_work_q[XLEN-2:0], d_ge};
    acc_n   = is_div_q ? d_acc : m_acc;
    lo_n    = is_div_q ? d_lo  : m_lo;
    prod     = {acc_n, lo_n};
    prod_fix = neg_res_q ? (-prod) : prod;
    if (!is_div_q) begin
      hi_res = prod_fix[2*XLEN-1:XLEN];
      lo_res = prod_fix[XLEN-1:0];
    end else if (div0_q) begin
      hi_res = a_raw_q;
      lo_res = '1;
    end else begin
      hi_res = neg_rem_q ? (-acc_n) : acc_n;
      lo_res = neg_res_q ? (-lo_n) : lo_n;
    end
  end

  // Datapath: latch operands on issue, iterate in BUSY, write HI/LO on the last step.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      lo_work_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (state_q == S_IDLE && start) begin
      cnt_q     <= CNT_W'(XLEN);
      is_div_q  <= MdOpE[1];
      neg_res_q <= sgn & (SrcAE[XLEN-1] ^ SrcBE[XLEN-1]);
      neg_rem_q <= sgn & SrcAE[XLEN-1];
      div0_q    <= MdOpE[1] & (SrcBE == '0);
      a_raw_q   <= SrcAE;
      b_mag_q   <= b_mag;
      acc_q     <= '0;
      lo_work_q <= a_mag;
    end else if (state_q == S_BUSY && !FlushE) begin
      cnt_q     <= cnt_q - CNT_W'(1);
      acc_q     <= acc_n;
      lo_work_q <= lo_n;
      if (last) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end
    end
  end

  // ALU and mfhi/mflo result mux.
  always_comb begin
    case (ALUControlE)
      4'b0010: ALUResultE = SrcAE + SrcBE;
      4'b0110: ALUResultE = SrcAE - SrcBE;
      4'b0000: ALUResultE = SrcAE & SrcBE;
      4'b0001: ALUResultE = SrcAE | SrcBE;
      4'b0011: ALUResultE = SrcAE ^ SrcBE;
      4'b1100: ALUResultE = ~(SrcAE | SrcBE);
      4'b0111: ALUResultE = {{(XLEN-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
      4'b0100: ALUResultE = SrcBE << SrcAE[SHAMT_W-1:0];
      4'b0101: ALUResultE = SrcBE >> SrcAE[SHAMT_W-1:0];
      4'b1000: ALUResultE = $unsigned($signed(SrcBE) >>> SrcAE[SHAMT_W-1:0]);
      default: ALUResultE = '0;
    endcase
    if (MdOpE == 3'b010) ALUResultE = hi_q;
    if (MdOpE == 3'b011) ALUResultE = lo_q;
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage. It runs an ALU vector table, then hand-written
// muldiv sequences covering latency, signs, divide-by-zero, overflow, flush,
// reset, and a 16-bit build.
module tb_ex_muldiv_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit DUT
  logic [3:0]  alu;
  logic [2:0]  md;
  logic        flush;
  logic [31:0] srca, srcb;
  logic [31:0] res, hi, lo;
  logic        stall, busy;
  logic [1:0]  st;

  ex_muldiv_stage #(.XLEN(32)) dut (
    .Clock(clk), .Reset(rst), .ALUControlE(alu), .MdOpE(md), .FlushE(flush),
    .SrcAE(srca), .SrcBE(srcb), .ALUResultE(res), .StallE(stall),
    .HI(hi), .LO(lo), .BusyE(busy), .DbgStateE(st)
  );

  // 16-bit DUT
  logic [3:0]  alu16;
  logic [2:0]  md16;
  logic [15:0] a16, b16;
  logic [15:0] res16, hi16, lo16;
  logic        stall16, busy16;
  logic [1:0]  st16;

  ex_muldiv_stage #(.XLEN(16)) dut16 (
    .Clock(clk), .Reset(rst), .ALUControlE(alu16), .MdOpE(md16), .FlushE(1'b0),
    .SrcAE(a16), .SrcBE(b16), .ALUResultE(res16), .StallE(stall16),
    .HI(hi16), .LO(lo16), .BusyE(busy16), .DbgStateE(st16)
  );

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Issue a muldiv op in a fresh cycle. Count stall cycles (bounded) and check
  // HI/LO in the DONE cycle. The op stays asserted through DONE.
  task automatic run_md(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    md = op; srca = a; srcb = b; alu = 4'b0010;
    #1;
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #2;
    end
    check({name, ".stall_cycles"}, 64'(cyc), 64'd33);
    check({name, ".state_done"}, 64'(st), 64'(ST_DONE));
    check({name, ".hi"}, 64'(hi), 64'(eh));
    check({name, ".lo"}, 64'(lo), 64'(el));
  endtask

  task automatic mf(input string name, input logic [2:0] op, input logic [31:0] exp);
    @(posedge clk); #1;
    md = op;
    #1;
    check(name, 64'(res), 64'(exp));
    md = 3'b000;
  endtask

  // ---------------- ALU vector table ----------------
  typedef struct {
    logic [3:0]  alu;
    logic [2:0]  md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[15];

  initial begin
    int cyc;
    vecs[0]  = '{4'b0010, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{4'b0010, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[2]  = '{4'b0110, 3'b000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[3]  = '{4'b0000, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[4]  = '{4'b0001, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vecs[5]  = '{4'b0011, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[6]  = '{4'b1100, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F};
    vecs[7]  = '{4'b0111, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[8]  = '{4'b0111, 3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{4'b0100, 3'b000, 32'h0000_0024, 32'h0000_000F, 32'h0000_00F0};
    vecs[10] = '{4'b0101, 3'b000, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000};
    vecs[11] = '{4'b1000, 3'b000, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000};
    vecs[12] = '{4'b1000, 3'b000, 32'h0000_0020, 32'h8000_0000, 32'h8000_0000};
    vecs[13] = '{4'b1111, 3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
    vecs[14] = '{4'b0010, 3'b001, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};

    alu = 4'b0000; md = 3'b100; flush = 1'b0; srca = '0; srcb = '0;
    alu16 = 4'b0000; md16 = 3'b000; a16 = '0; b16 = '0;

    // Reset state, with a start request held during reset.
    #2;
    check("rst.stall", 64'(stall), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    check("rst.state", 64'(st), 64'(ST_IDLE));
    @(posedge clk); #1;
    md = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU sweep
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      alu = vecs[i].alu; md = vecs[i].md; srca = vecs[i].a; srcb = vecs[i].b;
      #1;
      check($sformatf("alu[%0d].res", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("alu[%0d].stall", i), 64'(stall), 64'd0);
    end
    md = 3'b000;

    // Signed multiply, followed by mflo/mfhi.
    run_md("mult_m3x7", 3'b100, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    mf("mflo_after_mult", 3'b011, 32'hFFFF_FFEB);
    mf("mfhi_after_mult", 3'b010, 32'hFFFF_FFFF);

    // Divides, issued back to back directly after DONE.
    run_md("div_100_7", 3'b110, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("div_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_fff9_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);
    run_md("divu_by0", 3'b111, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF);
    run_md("div_by0_neg", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_md("div_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_md("mult_neg_neg", 3'b100, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6);
    run_md("multu_big", 3'b101, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

    // Flush mid-BUSY, with HI=5 and LO=9 preloaded (59 = 6*9 + 5).
    run_md("preload", 3'b111, 32'd59, 32'd6, 32'd5, 32'd9);
    @(posedge clk); #1;
    md = 3'b100; srca = 32'd3; srcb = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    check("flush.stall_same_cycle", 64'(stall), 64'd0);
    check("flush.busy_same_cycle", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; md = 3'b000;
    #1;
    check("flush.state_next", 64'(st), 64'(ST_IDLE));
    check("flush.hi", 64'(hi), 64'd5);
    check("flush.lo", 64'(lo), 64'd9);
    repeat (40) @(posedge clk);
    #1;
    check("flush.hi_later", 64'(hi), 64'd5);
    check("flush.lo_later", 64'(lo), 64'd9);

    // Flush in IDLE with a start pending: no start.
    @(posedge clk); #1;
    md = 3'b110; flush = 1'b1;
    #1;
    check("flush_idle.stall", 64'(stall), 64'd0);
    @(posedge clk); #2;
    check("flush_idle.state", 64'(st), 64'(ST_IDLE));
    md = 3'b000; flush = 1'b0;

    // Reset pulsed 10 cycles into a multu.
    @(posedge clk); #1;
    md = 3'b101; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst.stall", 64'(stall), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.lo", 64'(lo), 64'd0);
    check("midrst.state", 64'(st), 64'(ST_IDLE));
    @(posedge clk); #1;
    check("midrst.stall_held", 64'(stall), 64'd0);
    md = 3'b000;
    rst = 1'b0;
    mf("mfhi_after_rst", 3'b010, 32'd0);
    mf("mflo_after_rst", 3'b011, 32'd0);
    run_md("multu_after_rst", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(posedge clk); #1;
    md = 3'b000;

    // 16-bit build: ALU checks and mult latency.
    alu16 = 4'b1000; a16 = 16'd4; b16 = 16'h8000;
    #1;
    check("x16.sra", 64'(res16), 64'hF800);
    alu16 = 4'b0110; a16 = 16'd0; b16 = 16'd1;
    #1;
    check("x16.sub", 64'(res16), 64'hFFFF);
    alu16 = 4'b0111; a16 = 16'hFFFF; b16 = 16'd1;
    #1;
    check("x16.slt", 64'(res16), 64'd1);
    @(posedge clk); #1;
    md16 = 3'b100; a16 = 16'hFFFD; b16 = 16'd7;
    #1;
    cyc = 0;
    while (stall16 === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #2;
    end
    check("x16.mult.stall_cycles", 64'(cyc), 64'd17);
    check("x16.mult.hi", 64'(hi16), 64'hFFFF);
    check("x16.mult.lo", 64'(lo16), 64'hFFEB);
    md16 = 3'b000;

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
